// File: rtl/fir_stream_ctrl.sv
// fir_stream_ctrl: moves one byte at a time from the RX FIFO through the FIR
// filter stage into the TX FIFO, with a single sample in flight.
module fir_stream_ctrl #(
  parameter int unsigned DBITS    = 8,
  parameter int unsigned FILT_LAT = 4,
  parameter int unsigned CNT_BITS = 16
) (
  input  logic                clk_100MHz,
  input  logic                reset_btn,
  input  logic                enable,
  input  logic                rx_empty,
  input  logic                rx_full,
  input  logic [DBITS-1:0]    rx_data,
  output logic                rd_uart,
  output logic [DBITS-1:0]    filt_x,
  output logic                filt_valid,
  input  logic [DBITS-1:0]    filt_y,
  input  logic                tx_full,
  output logic [DBITS-1:0]    tx_data,
  output logic                wr_uart,
  output logic                busy,
  output logic [CNT_BITS-1:0] sample_count,
  output logic                overflow_sticky
);

  localparam int unsigned WBITS = (FILT_LAT > 1) ? $clog2(FILT_LAT) : 1;
  localparam logic [WBITS-1:0] WAIT_INIT = WBITS'(FILT_LAT - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_POP  = 3'd1;
  localparam logic [2:0] S_FEED = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_PUSH = 3'd4;

  logic [2:0]       state;
  logic [2:0]       state_next;
  logic [DBITS-1:0] sample_reg;
  logic [DBITS-1:0] result_reg;
  logic [WBITS-1:0] wait_cnt;
  logic             push_next;

  // sample_reg is loaded on the POP->FEED edge, so filt_x only moves entering FEED.
  assign filt_x  = sample_reg;
  assign tx_data = result_reg;

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (enable && !rx_empty) state_next = S_POP;
      S_POP:   state_next = S_FEED;
      S_FEED:  state_next = S_WAIT;
      S_WAIT:  if (wait_cnt == '0) state_next = S_PUSH;
      S_PUSH:  if (wr_uart) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // wr_uart is registered: a push cycle follows a cycle in which tx_full was low.
  assign push_next = (state_next == S_PUSH) && !tx_full;

  always_ff @(posedge clk_100MHz) begin
    if (reset_btn) begin
      state           <= S_IDLE;
      sample_reg      <= '0;
      result_reg      <= '0;
      wait_cnt        <= '0;
      rd_uart         <= 1'b0;
      filt_valid      <= 1'b0;
      wr_uart         <= 1'b0;
      busy            <= 1'b0;
      sample_count    <= '0;
      overflow_sticky <= 1'b0;
    end else begin
      state      <= state_next;
      busy       <= (state_next != S_IDLE);
      rd_uart    <= (state_next == S_POP);
      filt_valid <= (state_next == S_FEED);
      wr_uart    <= push_next;
      if (rx_full) overflow_sticky <= 1'b1;

      case (state)
        S_POP:  sample_reg <= rx_data;
        S_FEED: wait_cnt <= WAIT_INIT;
        S_WAIT: begin
          if (wait_cnt == '0) result_reg <= filt_y;
          else wait_cnt <= wait_cnt - WBITS'(1);
        end
        S_PUSH: if (wr_uart) sample_count <= sample_count + CNT_BITS'(1);
        default: ;
      endcase
    end
  end

endmodule
